// File: rtl/dfd_xtrigger_receive_qualifier.sv
// Receive-side cross-trigger conditioning: per channel synchronizer, min-width qualifier,
// single-cycle pulse generation, re-trigger holdoff and saturating event/glitch status.
module dfd_xtrigger_receive_qualifier #(
    parameter int unsigned XTRIGGER_WIDTH  = 2,
    parameter int unsigned QUAL_CNTR_WIDTH = 8,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [XTRIGGER_WIDTH-1:0]                 xtrigger_in_async,
    input  logic [XTRIGGER_WIDTH-1:0]                 cfg_enable,
    input  logic [XTRIGGER_WIDTH*QUAL_CNTR_WIDTH-1:0] cfg_min_width,
    input  logic [XTRIGGER_WIDTH*QUAL_CNTR_WIDTH-1:0] cfg_holdoff,
    input  logic                                      cfg_status_clr,
    output logic [XTRIGGER_WIDTH-1:0]                 xtrigger_pulse_out,
    output logic [XTRIGGER_WIDTH-1:0]                 xtrigger_level_out,
    output logic [XTRIGGER_WIDTH*QUAL_CNTR_WIDTH-1:0] xtrigger_event_cnt,
    output logic [XTRIGGER_WIDTH-1:0]                 xtrigger_glitch_seen
);

    localparam int unsigned CW = QUAL_CNTR_WIDTH;
    localparam int unsigned SS = SYNC_STAGES;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_e;

    for (genvar ch = 0; ch < int'(XTRIGGER_WIDTH); ch++) begin : g_ch

        logic [SS-1:0] sync_q;
        logic          sync_s;

        state_e        state_q, state_d;
        logic [CW-1:0] qcnt_q, qcnt_d;
        logic [CW-1:0] hcnt_q, hcnt_d;
        logic          pulse_q, pulse_d;
        logic          level_q, level_d;
        logic          glitch_q, glitch_d;
        logic [CW-1:0] evcnt_q, evcnt_d;

        logic [CW-1:0] cfg_min_c;
        logic [CW-1:0] cfg_hold_c;
        logic [CW-1:0] min_w_c;
        logic [CW:0]   qcnt_inc_c;
        logic [CW:0]   hcnt_inc_c;
        logic          en_c;
        logic          glitch_set_c;

        // Synchronizer runs regardless of enable so the channel sees a settled level when enabled.
        always_ff @(posedge clock) begin
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SS-2:0], xtrigger_in_async[ch]};
            end
        end

        assign sync_s     = sync_q[SS-1];
        assign en_c       = cfg_enable[ch];
        assign cfg_min_c  = cfg_min_width[ch*CW +: CW];
        assign cfg_hold_c = cfg_holdoff[ch*CW +: CW];
        assign min_w_c    = (cfg_min_c == '0) ? CW'(1) : cfg_min_c;
        // One extra bit so a target lowered below the running count compares without wrapping.
        assign qcnt_inc_c = {1'b0, qcnt_q} + (CW + 1)'(1);
        assign hcnt_inc_c = {1'b0, hcnt_q} + (CW + 1)'(1);

        always_ff @(posedge clock) begin
            if (reset) begin
                state_q  <= ST_IDLE;
                qcnt_q   <= '0;
                hcnt_q   <= '0;
                pulse_q  <= 1'b0;
                level_q  <= 1'b0;
                glitch_q <= 1'b0;
                evcnt_q  <= '0;
            end else begin
                state_q  <= state_d;
                qcnt_q   <= qcnt_d;
                hcnt_q   <= hcnt_d;
                pulse_q  <= pulse_d;
                level_q  <= level_d;
                glitch_q <= glitch_d;
                evcnt_q  <= evcnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            qcnt_d  = qcnt_q;
            hcnt_d  = hcnt_q;
            if (!en_c) begin
                state_d = ST_IDLE;
                qcnt_d  = '0;
                hcnt_d  = '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (sync_s) begin
                            if (min_w_c == CW'(1)) begin
                                state_d = ST_ACTIVE;
                            end else begin
                                state_d = ST_QUAL;
                                qcnt_d  = CW'(1);
                            end
                        end
                    end
                    ST_QUAL: begin
                        if (!sync_s) begin
                            state_d = ST_IDLE;
                            qcnt_d  = '0;
                        end else if (qcnt_inc_c >= {1'b0, min_w_c}) begin
                            state_d = ST_ACTIVE;
                            qcnt_d  = '0;
                        end else begin
                            qcnt_d = qcnt_inc_c[CW-1:0];
                        end
                    end
                    ST_ACTIVE: begin
                        if (!sync_s) begin
                            if (cfg_hold_c != '0) begin
                                state_d = ST_HOLDOFF;
                                hcnt_d  = '0;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                    ST_HOLDOFF: begin
                        if (hcnt_inc_c >= {1'b0, cfg_hold_c}) begin
                            state_d = ST_IDLE;
                            hcnt_d  = '0;
                        end else begin
                            hcnt_d = hcnt_inc_c[CW-1:0];
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        qcnt_d  = '0;
                        hcnt_d  = '0;
                    end
                endcase
            end
        end

        // Pulse marks entry into ACTIVE; status clear dominates any same-cycle update.
        always_comb begin
            pulse_d      = 1'b0;
            level_d      = 1'b0;
            glitch_set_c = 1'b0;
            glitch_d     = glitch_q;
            evcnt_d      = evcnt_q;

            pulse_d      = en_c && (state_d == ST_ACTIVE) && (state_q != ST_ACTIVE);
            level_d      = en_c && (state_d == ST_ACTIVE);
            glitch_set_c = en_c && (state_q == ST_QUAL) && !sync_s;

            if (cfg_status_clr) begin
                glitch_d = 1'b0;
                evcnt_d  = '0;
            end else begin
                glitch_d = glitch_q | glitch_set_c;
                if (pulse_d && (evcnt_q != '1)) begin
                    evcnt_d = evcnt_q + CW'(1);
                end
            end
        end

        assign xtrigger_pulse_out[ch]          = pulse_q;
        assign xtrigger_level_out[ch]          = level_q;
        assign xtrigger_glitch_seen[ch]        = glitch_q;
        assign xtrigger_event_cnt[ch*CW +: CW] = evcnt_q;
    end

endmodule

// File: tb/tb_dfd_xtrigger_receive_qualifier.sv
// Scoreboarded bench: driver runs a behavioural channel model and queues expected outputs,
// a monitor pops one expectation per cycle and compares it against the DUT.
module tb_dfd_xtrigger_receive_qualifier;

    localparam int unsigned XW = 2;
    localparam int unsigned CW = 8;
    localparam int unsigned SS = 2;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic [XW-1:0]     xtrigger_in_async;
    logic [XW-1:0]     cfg_enable;
    logic [XW*CW-1:0]  cfg_min_width;
    logic [XW*CW-1:0]  cfg_holdoff;
    logic              cfg_status_clr;
    logic [XW-1:0]     xtrigger_pulse_out;
    logic [XW-1:0]     xtrigger_level_out;
    logic [XW*CW-1:0]  xtrigger_event_cnt;
    logic [XW-1:0]     xtrigger_glitch_seen;

    always #5 clock = ~clock;

    dfd_xtrigger_receive_qualifier #(
        .XTRIGGER_WIDTH (XW),
        .QUAL_CNTR_WIDTH(CW),
        .SYNC_STAGES    (SS)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .xtrigger_in_async   (xtrigger_in_async),
        .cfg_enable          (cfg_enable),
        .cfg_min_width       (cfg_min_width),
        .cfg_holdoff         (cfg_holdoff),
        .cfg_status_clr      (cfg_status_clr),
        .xtrigger_pulse_out  (xtrigger_pulse_out),
        .xtrigger_level_out  (xtrigger_level_out),
        .xtrigger_event_cnt  (xtrigger_event_cnt),
        .xtrigger_glitch_seen(xtrigger_glitch_seen)
    );

    typedef struct {
        logic [XW-1:0]    pulse;
        logic [XW-1:0]    level;
        logic [XW-1:0]    glitch;
        logic [XW*CW-1:0] cnt;
        int               cyc;
    } snap_t;

    snap_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;

    // Stimulus for the next edge
    bit          r_reset;
    bit [XW-1:0] r_in;
    bit [XW-1:0] r_en;
    int          r_min [XW];
    int          r_hold[XW];
    bit          r_clr;

    // Reference model: input delay line, qualified run length, active flag, holdoff timer
    int m_hist  [XW][SS];
    int m_run   [XW];
    bit m_active[XW];
    bit m_hold  [XW];
    int m_hold_el[XW];
    int m_cnt   [XW];
    bit m_glitch[XW];

    function automatic void chk(input string nm, input int c, input logic [31:0] got,
                                input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, got, expv);
    endfunction

    function automatic void model_step();
        snap_t s;
        s.pulse = '0; s.level = '0; s.glitch = '0; s.cnt = '0; s.cyc = cyc;
        for (int ch = 0; ch < int'(XW); ch++) begin
            bit pulse = 0;
            bit gset  = 0;
            if (r_reset) begin
                for (int k = 0; k < int'(SS); k++) m_hist[ch][k] = 0;
                m_run[ch] = 0; m_active[ch] = 0; m_hold[ch] = 0; m_hold_el[ch] = 0;
                m_cnt[ch] = 0; m_glitch[ch] = 0;
            end else begin
                int sv = m_hist[ch][SS-1];
                int mw = (r_min[ch] == 0) ? 1 : r_min[ch];
                for (int k = int'(SS) - 1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
                m_hist[ch][0] = int'(r_in[ch]);
                if (!r_en[ch]) begin
                    m_run[ch] = 0; m_active[ch] = 0; m_hold[ch] = 0; m_hold_el[ch] = 0;
                end else if (m_hold[ch]) begin
                    m_hold_el[ch]++;
                    if (m_hold_el[ch] >= r_hold[ch]) m_hold[ch] = 0;
                end else if (m_active[ch]) begin
                    if (sv == 0) begin
                        m_active[ch] = 0;
                        if (r_hold[ch] > 0) begin
                            m_hold[ch] = 1; m_hold_el[ch] = 0;
                        end
                    end
                end else if (sv != 0) begin
                    m_run[ch]++;
                    if (m_run[ch] >= mw) begin
                        pulse = 1; m_active[ch] = 1; m_run[ch] = 0;
                    end
                end else begin
                    if (m_run[ch] > 0) gset = 1;
                    m_run[ch] = 0;
                end
                if (r_clr) begin
                    m_cnt[ch] = 0; m_glitch[ch] = 0;
                end else begin
                    if (pulse && m_cnt[ch] < CNT_MAX) m_cnt[ch]++;
                    m_glitch[ch] = m_glitch[ch] | gset;
                end
            end
            s.pulse[ch]          = pulse;
            s.level[ch]          = m_active[ch];
            s.glitch[ch]         = m_glitch[ch];
            s.cnt[ch*CW +: CW]   = CW'(m_cnt[ch]);
        end
        exp_q.push_back(s);
    endfunction

    task automatic cycle();
        @(negedge clock);
        reset             = r_reset;
        xtrigger_in_async = r_in;
        cfg_enable        = r_en;
        for (int i = 0; i < int'(XW); i++) begin
            cfg_min_width[i*CW +: CW] = CW'(r_min[i]);
            cfg_holdoff[i*CW +: CW]   = CW'(r_hold[i]);
        end
        cfg_status_clr = r_clr;
        model_step();
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic high0(input int hi, input int lo);
        r_in[0] = 1'b1; run(hi);
        r_in[0] = 1'b0; run(lo);
    endtask

    // Monitor: one expectation per clock, sampled just after the active edge
    initial begin
        snap_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pulse",  e.cyc, 32'(xtrigger_pulse_out),   32'(e.pulse));
                chk("level",  e.cyc, 32'(xtrigger_level_out),   32'(e.level));
                chk("glitch", e.cyc, 32'(xtrigger_glitch_seen), 32'(e.glitch));
                chk("evcnt",  e.cyc, 32'(xtrigger_event_cnt),   32'(e.cnt));
            end
        end
    end

    initial begin
        int run_left[XW];
        bit lvl[XW];
        reset = 1'b1; xtrigger_in_async = '0; cfg_enable = '0;
        cfg_min_width = '0; cfg_holdoff = '0; cfg_status_clr = 1'b0;
        r_reset = 1; r_in = '0; r_en = '1; r_clr = 0;
        for (int i = 0; i < int'(XW); i++) begin
            r_min[i] = 1; r_hold[i] = 0; run_left[i] = 0; lvl[i] = 0;
        end
        run(3);
        r_reset = 0;
        run(2);

        // Basic pulse with minimum width one
        high0(5, 10);
        // Glitch below min width, then a qualifying assertion
        r_min[0] = 4;
        high0(3, 8);
        high0(6, 10);
        // Holdoff swallows a close re-trigger but not a distant one
        r_min[0] = 1; r_hold[0] = 10;
        high0(3, 4); high0(3, 20);
        high0(3, 14); high0(3, 20);
        r_hold[0] = 0;
        // Reset during qualification and during active
        r_min[0] = 5;
        r_in[0] = 1; run(3); r_reset = 1; run(1); r_reset = 0; r_in[0] = 0; run(8);
        r_min[0] = 1;
        r_in[0] = 1; run(4); r_reset = 1; run(1); r_reset = 0; r_in[0] = 0; run(8);
        // Event counter saturation, then clear coincident with a pulse
        for (int i = 0; i < 262; i++) high0(1, 1);
        r_in[0] = 1; run(1); r_in[0] = 0; r_clr = 1; run(1); r_in[0] = 1; run(1);
        r_in[0] = 0; run(1); r_clr = 0;
        high0(1, 6);
        // Simultaneous channels with different widths, then drop enable on ch0
        r_min[0] = 1; r_min[1] = 3;
        r_in = '1; run(5);
        r_en[0] = 0; run(3); r_en[0] = 1;
        run(4); r_in = '0; run(10);
        // Lower min width mid-qualification
        r_min[1] = 6; r_in[1] = 1; run(5); r_min[1] = 2; run(4); r_in[1] = 0; run(6);

        // Randomized traffic with occasional config, enable, clear and reset events
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < int'(XW); i++) begin
                if (run_left[i] == 0) begin
                    lvl[i] = ~lvl[i];
                    run_left[i] = int'($urandom_range(1, 12));
                end
                run_left[i]--;
                r_in[i] = lvl[i];
                if ($urandom_range(0, 59) == 0) r_min[i]  = int'($urandom_range(0, 6));
                if ($urandom_range(0, 59) == 0) r_hold[i] = int'($urandom_range(0, 12));
                if ($urandom_range(0, 99) == 0) r_en[i]   = ~r_en[i];
            end
            r_clr   = ($urandom_range(0, 149) == 0);
            r_reset = ($urandom_range(0, 499) == 0);
            cycle();
        end
        r_reset = 0; r_clr = 0; r_in = '0; r_en = '1;
        run(20);

        @(posedge clock); @(posedge clock); #2;
        chk("drain", cyc, 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
